serv_bus_responder: RTL and testbench
=====================================

SERV_BUS_RESPONDER -- requirements
Module: serv_bus_responder

Interface
REQ-001 The block SHALL have parameter AW, default 8, giving the word-address width (memory depth 2^AW 32-bit words).
REQ-002 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the stall LFSR reset value.
REQ-003 The block SHALL have port clock, input, 1, system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port ibus_adr, input, 32, instruction fetch byte address.
REQ-006 The block SHALL have port ibus_cyc, input, 1, instruction fetch request.
REQ-007 The block SHALL have port ibus_rdt, output, 32, instruction read data.
REQ-008 The block SHALL have port ibus_ack, output, 1, instruction fetch completion.
REQ-009 The block SHALL have port dbus_adr, input, 32, data byte address.
REQ-010 The block SHALL have port dbus_dat, input, 32, data write data.
REQ-011 The block SHALL have port dbus_sel, input, 4, write byte-lane enables.
REQ-012 The block SHALL have port dbus_we, input, 1, data write (1) or read (0).
REQ-013 The block SHALL have port dbus_cyc, input, 1, data request.
REQ-014 The block SHALL have port dbus_rdt, output, 32, data read data.
REQ-015 The block SHALL have port dbus_ack, output, 1, data completion.

Function
REQ-016 Both buses SHALL share one internal 2^AW x 32 memory, with word index = adr[AW+1:2] and adr[1:0] plus upper bits ignored, so addresses wrap modulo 2^(AW+2).
REQ-017 The FSM SHALL have states IDLE, WAIT and ACK, plus a 1-bit owner register (I or D).
REQ-018 In IDLE, dbus_cyc=1 SHALL select owner D, otherwise ibus_cyc=1 SHALL select owner I, and the FSM SHALL move to WAIT with the stall count loaded; with both cyc high, dbus SHALL win and ibus SHALL be served afterwards.
REQ-019 In WAIT, the FSM SHALL move to ACK when the stall count is 0, and otherwise decrement the count.
REQ-020 In IDLE or WAIT, if the owner's cyc is low, the FSM SHALL return to IDLE without ack and without writing memory.
REQ-021 In ACK, the owner's ack SHALL equal the owner's cyc, combinationally gated, and the FSM SHALL return to IDLE the next cycle, so ack is a single-cycle pulse and never asserts while cyc is low.
REQ-022 Read data SHALL equal mem[index] on the owner's rdt during the ack cycle, and both rdt outputs SHALL be 0 in all other cycles.
REQ-023 A dbus write SHALL update only the byte lanes with dbus_sel[n]=1, at the clock edge ending the ack cycle; sel=4'b0000 SHALL still ack with no change.
REQ-024 ibus_ack and dbus_ack SHALL never be high in the same cycle.
REQ-025 Minimum latency SHALL be: cyc seen in IDLE at cycle N, ack at cycle N+2; the FSM SHALL spend at least one IDLE cycle between accesses.

Reset
REQ-026 While reset=1, the FSM SHALL be IDLE, owner SHALL be I, stall count SHALL be 0, LFSR SHALL equal LFSR_SEED, and ibus_ack, dbus_ack, ibus_rdt and dbus_rdt SHALL all be 0.
REQ-027 Reset asserted mid-access SHALL abort the access with no ack and no memory write.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 The macro SERV_RESPONDER_STALL_EN SHALL control the stall behaviour.
REQ-030 With SERV_RESPONDER_STALL_EN defined, the stall count SHALL load LFSR[2:0] (0..6; value 7 clamps to 6), the 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per accepted request, and maximum latency cyc-to-ack SHALL be 8 cycles.
REQ-031 With SERV_RESPONDER_STALL_EN undefined, the stall count SHALL always load 0, the LFSR SHALL be absent, and latency SHALL be fixed at 2 cycles.

Verification
REQ-032 Write 32'hDEADBEEF, sel=4'hF, to dbus_adr 0x10, then read ibus_adr 0x10 -> ibus_rdt=32'hDEADBEEF for exactly one ack cycle.
REQ-033 Write 32'h000000AA, sel=4'b0001, over 32'h11223344 at 0x20, then read dbus -> dbus_rdt=32'h112233AA.
REQ-034 ibus_cyc and dbus_cyc rise together -> dbus_ack first, ibus_ack later, never both in the same cycle.
REQ-035 dbus write request with dbus_cyc dropped during WAIT (stall enabled) -> no dbus_ack, and memory unchanged on readback.
REQ-036 Assert reset during WAIT of a write -> acks stay 0, rdt stays 0, memory unchanged, next access completes normally.
REQ-037 Issue 1000 random requests with stall enabled -> every cyc-to-ack latency is between 2 and 8; AW=8 write to 0x400 aliases to 0x000.

Source files
------------

// File: rtl/serv_bus_responder.sv
// Shared-memory responder for the SERV instruction and data buses, with a single arbiter FSM.
// Optional pseudo-random stall insertion is enabled by defining SERV_RESPONDER_STALL_EN.
module serv_bus_responder #(
    parameter int unsigned AW        = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ibus_adr,
    input  logic        ibus_cyc,
    output logic [31:0] ibus_rdt,
    output logic        ibus_ack,
    input  logic [31:0] dbus_adr,
    input  logic [31:0] dbus_dat,
    input  logic [3:0]  dbus_sel,
    input  logic        dbus_we,
    input  logic        dbus_cyc,
    output logic [31:0] dbus_rdt,
    output logic        dbus_ack
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_d;
    logic            owner_nxt;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   stall_nxt;
    logic [CW-1:0]   stall_load;
    logic            load_rd;
    logic [31:0]     rd_data;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic            owner_cyc;
    logic            ack_c;
    logic            mem_we_c;

    logic [31:0]     mem [DEPTH];

    // Only the word index takes part in decoding; the rest of each address is don't-care.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{ibus_adr[31:AW+2], ibus_adr[1:0],
                               dbus_adr[31:AW+2], dbus_adr[1:0]};

    assign owner_cyc = owner_d ? dbus_cyc : ibus_cyc;
    assign rd_idx    = owner_d ? dbus_adr[AW+1:2] : ibus_adr[AW+1:2];
    assign wr_idx    = dbus_adr[AW+1:2];

    // Ack follows the owner's cyc inside the ACK state so it never outlives the request.
    assign ack_c    = (state == S_ACK) && owner_cyc && !reset;
    assign mem_we_c = ack_c && owner_d && dbus_we;

    assign ibus_ack = ack_c && !owner_d;
    assign dbus_ack = ack_c && owner_d;
    assign ibus_rdt = ibus_ack ? rd_data : 32'd0;
    assign dbus_rdt = dbus_ack ? rd_data : 32'd0;

`ifdef SERV_RESPONDER_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        accept_c;

    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign accept_c   = (state == S_IDLE) && (dbus_cyc || ibus_cyc);
    assign stall_load = (lfsr[2:0] == 3'd7) ? 3'd6 : lfsr[2:0];

    // Fibonacci LFSR, stepped once per accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (accept_c) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign stall_load = CW'(0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            stall_cnt <= CW'(0);
            rd_data   <= 32'd0;
        end else begin
            state     <= state_nxt;
            owner_d   <= owner_nxt;
            stall_cnt <= stall_nxt;
            if (load_rd) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

    // Arbitration and stall sequencing; dbus has priority when both request in IDLE.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_d;
        stall_nxt = stall_cnt;
        load_rd   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dbus_cyc) begin
                    owner_nxt = 1'b1;
                    stall_nxt = stall_load;
                    state_nxt = S_WAIT;
                end else if (ibus_cyc) begin
                    owner_nxt = 1'b0;
                    stall_nxt = stall_load;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!owner_cyc) begin
                    state_nxt = S_IDLE;
                end else if (stall_cnt == CW'(0)) begin
                    load_rd   = 1'b1;
                    state_nxt = S_ACK;
                end else begin
                    stall_nxt = stall_cnt - CW'(1);
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte-lane write, committed on the edge that closes the dbus ack cycle; never reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (dbus_sel[b]) begin
                    mem[wr_idx][8*b +: 8] <= dbus_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_serv_bus_responder.sv
// Directed and randomised checks for serv_bus_responder: arbitration, byte lanes, aborts,
// reset behaviour, latency bounds and address aliasing.
module tb_serv_bus_responder;

`ifdef SERV_RESPONDER_STALL_EN
    localparam int MAX_LAT = 8;
`else
    localparam int MAX_LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];

    serv_bus_responder dut (
        .clock    (clock),
        .reset    (reset),
        .ibus_adr (ibus_adr),
        .ibus_cyc (ibus_cyc),
        .ibus_rdt (ibus_rdt),
        .ibus_ack (ibus_ack),
        .dbus_adr (dbus_adr),
        .dbus_dat (dbus_dat),
        .dbus_sel (dbus_sel),
        .dbus_we  (dbus_we),
        .dbus_cyc (dbus_cyc),
        .dbus_rdt (dbus_rdt),
        .dbus_ack (dbus_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access from an IDLE-aligned start; lat counts cycles from request to ack (-1 = none).
    task automatic bus_xfer(input bit use_d, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit we,
                            output logic [31:0] rdt, output int lat);
        if (use_d) begin
            dbus_adr = adr;
            dbus_dat = dat;
            dbus_sel = sel;
            dbus_we  = we;
            dbus_cyc = 1'b1;
        end else begin
            ibus_adr = adr;
            ibus_cyc = 1'b1;
        end
        lat = -1;
        rdt = 32'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (use_d ? dbus_ack : ibus_ack) begin
                lat = i;
                rdt = use_d ? dbus_rdt : ibus_rdt;
                break;
            end
        end
        @(posedge clock);
        #1;
        dbus_cyc = 1'b0;
        ibus_cyc = 1'b0;
        dbus_we  = 1'b0;
    endtask

    task automatic check_lat(input string tag, input int lat);
        check(tag, 32'(lat >= 2 && lat <= MAX_LAT), 32'd1);
    endtask

    logic [31:0] r;
    int          lat;
    int          d_at;
    int          i_at;
    logic [31:0] d_rdt;
    logic [31:0] i_rdt;
    bit          seen_ack;
    int          k;
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    initial begin
        reset    = 1'b1;
        ibus_adr = 32'd0;
        ibus_cyc = 1'b1;
        dbus_adr = 32'd0;
        dbus_dat = 32'd0;
        dbus_sel = 4'd0;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        check("rst_irdt", ibus_rdt, 32'd0);
        check("rst_drdt", dbus_rdt, 32'd0);
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full-word write then instruction read of the same word.
        bus_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, r, lat);
        check_lat("wr10_lat", lat);
        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ibus_ack) begin
                lat = i;
                r   = ibus_rdt;
                break;
            end
        end
        check_lat("rd10_lat", lat);
        check("rd10_data", r, 32'hDEADBEEF);
        @(negedge clock);
        check("rd10_pulse", {31'd0, ibus_ack}, 32'd0);
        check("rd10_rdt0", ibus_rdt, 32'd0);
        @(negedge clock);
        check("rd10_pulse2", {31'd0, ibus_ack}, 32'd0);
        @(posedge clock);
        #1;
        ibus_cyc = 1'b0;
        @(negedge clock);
        check("gated_ack", {31'd0, ibus_ack}, 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Byte-lane merges, including an all-lanes-off write.
        bus_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, r, lat);
        bus_xfer(1'b1, 32'h20, 32'h000000AA, 4'b0001, 1'b1, r, lat);
        bus_xfer(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, r, lat);
        check_lat("rd20_lat", lat);
        check("sel0001", r, 32'h112233AA);
        bus_xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, r, lat);
        check_lat("sel0_lat", lat);
        bus_xfer(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, r, lat);
        check("sel0000", r, 32'h112233AA);
        bus_xfer(1'b1, 32'h20, 32'hA1B2C3D4, 4'b1010, 1'b1, r, lat);
        bus_xfer(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, r, lat);
        check("sel1010", r, 32'hA122C3AA);

        // Simultaneous requests: dbus served first, never overlapping acks.
        dbus_adr = 32'h10;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b1;
        ibus_adr = 32'h20;
        ibus_cyc = 1'b1;
        d_at = -1;
        i_at = -1;
        d_rdt = 32'd0;
        i_rdt = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            check("ack_excl", {31'd0, ibus_ack & dbus_ack}, 32'd0);
            if (dbus_ack && d_at < 0) begin
                d_at  = i;
                d_rdt = dbus_rdt;
            end
            if (ibus_ack && i_at < 0) begin
                i_at  = i;
                i_rdt = ibus_rdt;
            end
            @(posedge clock);
            #1;
            if (d_at >= 0) dbus_cyc = 1'b0;
            if (i_at >= 0) begin
                ibus_cyc = 1'b0;
                break;
            end
        end
        check("both_dfirst", 32'(d_at >= 0 && i_at > d_at), 32'd1);
        check("both_dlat", 32'(d_at >= 2 && d_at <= MAX_LAT), 32'd1);
        check("both_drdt", d_rdt, 32'hDEADBEEF);
        check("both_irdt", i_rdt, 32'hA122C3AA);
        @(posedge clock);
        #1;

        // Write abandoned while waiting: no ack and no memory change.
        bus_xfer(1'b1, 32'h30, 32'h55555555, 4'hF, 1'b1, r, lat);
        dbus_adr = 32'h30;
        dbus_dat = 32'h0;
        dbus_sel = 4'hF;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        @(posedge clock);
        #1;
        dbus_cyc = 1'b0;
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clock);
            seen_ack = seen_ack | dbus_ack;
        end
        check("abort_noack", {31'd0, seen_ack}, 32'd0);
        dbus_we = 1'b0;
        bus_xfer(1'b1, 32'h30, 32'h0, 4'h0, 1'b0, r, lat);
        check("abort_mem", r, 32'h55555555);

        // Reset in the middle of a write aborts it; the next access works.
        bus_xfer(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1, r, lat);
        dbus_adr = 32'h40;
        dbus_dat = 32'hFFFFFFFF;
        dbus_sel = 4'hF;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        seen_ack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            seen_ack = seen_ack | dbus_ack | ibus_ack;
            check("rst_mid_rdt", dbus_rdt | ibus_rdt, 32'd0);
        end
        check("rst_mid_noack", {31'd0, seen_ack}, 32'd0);
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, r, lat);
        check_lat("rst_after_lat", lat);
        check("rst_after_mem", r, 32'h12345678);
        bus_xfer(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r, lat);
        check("rst_keeps_mem", r, 32'hDEADBEEF);

        // Address aliasing: 0x400 wraps to word 0, byte offset ignored.
        bus_xfer(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1, r, lat);
        bus_xfer(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r, lat);
        check("alias_i", r, 32'hCAFEF00D);
        bus_xfer(1'b1, 32'h3, 32'h0, 4'h0, 1'b0, r, lat);
        check("alias_d", r, 32'hCAFEF00D);

        // Random traffic over a 16-word window, checked against a shadow model.
        for (int j = 0; j < 16; j++) begin
            model[j] = 32'h1000_0000 + 32'(j) * 32'h0101_0101;
            bus_xfer(1'b1, 32'h200 + 32'(j * 4), model[j], 4'hF, 1'b1, r, lat);
        end
        for (int n = 0; n < 1000; n++) begin
            k    = int'($urandom_range(0, 15));
            kind = int'($urandom_range(0, 2));
            a    = 32'h200 + 32'(k * 4) + 32'($urandom_range(0, 3))
                   + (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h0);
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            bus_xfer(kind != 0, a, d, s, kind == 2, r, lat);
            check_lat("rnd_lat", lat);
            if (kind == 2) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                check("rnd_rdt", r, model[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
